weight_fetch_scheduler: RTL and testbench

Sequences weight-tile fetches for `weight_controller` across all input-depth and output-depth pairs of a layer. Each pair is one request and covers two output depths, `od1` and `od1+1`. The block drives `weight_od1`/`weight_id` and a one-cycle read request toward weight memory. It then waits for memory's `weight_valid`, and paces requests on PE-array readiness. It sits between the main controller, which starts a layer, and the `weight_controller`/weight-memory pair.

---
 rtl/weight_fetch_scheduler.sv | 130 +++++++++++++
 tb/tb_weight_fetch_scheduler.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/weight_fetch_scheduler.sv
// Weight-tile fetch sequencer: walks (id, od1-pair) over a layer, issues one read per pair.
// Optional stall counter output enabled by defining WEIGHT_SCHED_STALL_CNT_EN.
module weight_fetch_scheduler #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned TO_W    = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_i,
  input  logic       abort_i,
  input  logic [7:0] total_od_i,
  input  logic [3:0] total_id_i,
  input  logic       pe_ready_i,
  input  logic       mem_valid_i,
  output logic [7:0] weight_od1_o,
  output logic [3:0] weight_id_o,
  output logic       rd_req_o,
  output logic [1:0] pair_mask_o,
  output logic       pe_load_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o
`ifdef WEIGHT_SCHED_STALL_CNT_EN
  ,
  output logic [15:0] stall_cnt_o
`endif
);

  typedef enum logic [2:0] {IDLE, ISSUE, REQ, WAIT_DATA, DONE} state_t;

  state_t          state, next_state;
  logic [7:0]      tot_od;
  logic [3:0]      tot_id;
  logic [TO_W-1:0] to_cnt;
  logic [8:0]      od_step;
  logic [7:0]      od_adv;
  logic            wrap, last_pair, accept, timed_out, start_ok, zero_size;

  function automatic logic [1:0] mask_for(input logic [7:0] od, input logic [7:0] tot);
    return (({1'b0, od} + 9'd1) >= {1'b0, tot}) ? 2'b01 : 2'b11;
  endfunction

  always_comb begin
    od_step   = {1'b0, weight_od1_o} + 9'd2;
    wrap      = od_step >= {1'b0, tot_od};
    od_adv    = wrap ? '0 : od_step[7:0];
    last_pair = wrap && (weight_id_o == (tot_id - 4'd1));
    accept    = (state == WAIT_DATA) && mem_valid_i;
    timed_out = (state == WAIT_DATA) && !mem_valid_i && (to_cnt == TO_W'(TIMEOUT));
    start_ok  = (state == IDLE) && start_i;
    zero_size = (total_od_i == '0) || (total_id_i == '0);
  end

  always_comb begin
    next_state = state;
    rd_req_o   = 1'b0;
    done_o     = 1'b0;
    busy_o     = (state != IDLE);
    case (state)
      IDLE:      if (start_i) next_state = zero_size ? DONE : ISSUE;
      ISSUE:     if (pe_ready_i) next_state = REQ;
      REQ: begin
        rd_req_o   = 1'b1;
        next_state = WAIT_DATA;
      end
      WAIT_DATA: begin
        if (mem_valid_i)    next_state = last_pair ? DONE : ISSUE;
        else if (timed_out) next_state = IDLE;
      end
      DONE: begin
        done_o     = 1'b1;
        next_state = IDLE;
      end
      default:   next_state = IDLE;
    endcase
    if (abort_i) next_state = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tot_od       <= '0;
      tot_id       <= '0;
      weight_od1_o <= '0;
      weight_id_o  <= '0;
      pair_mask_o  <= '0;
      pe_load_o    <= 1'b0;
      err_o        <= 1'b0;
      to_cnt       <= '0;
    end else begin
      pe_load_o <= accept && !abort_i;
      // Counter reads 0 during REQ and k in the k-th WAIT_DATA cycle after it.
      if (state == REQ || state == WAIT_DATA) to_cnt <= to_cnt + 1'b1;
      else                                    to_cnt <= '0;
      if (!abort_i) begin
        if (start_ok) begin
          tot_od       <= total_od_i;
          tot_id       <= total_id_i;
          weight_od1_o <= '0;
          weight_id_o  <= '0;
          err_o        <= 1'b0;
          pair_mask_o  <= zero_size ? 2'b00 : mask_for('0, total_od_i);
        end else if (accept) begin
          weight_od1_o <= od_adv;
          if (wrap) weight_id_o <= weight_id_o + 4'd1;
          pair_mask_o  <= mask_for(od_adv, tot_od);
        end else if (timed_out) begin
          err_o <= 1'b1;
        end
      end
    end
  end

`ifdef WEIGHT_SCHED_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_o <= '0;
    end else if (start_ok && !abort_i) begin
      stall_cnt_o <= '0;
    end else if (((state == ISSUE && !pe_ready_i) || state == WAIT_DATA) && stall_cnt_o != '1) begin
      stall_cnt_o <= stall_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_weight_fetch_scheduler.sv
// Self-checking bench for weight_fetch_scheduler: directed layers plus randomized layers
// checked against a nested-loop request list built from the iteration rules.
module tb_weight_fetch_scheduler;

  logic       clk = 1'b0;
  logic       reset, start_i, abort_i, pe_ready_i, mem_valid_i;
  logic [7:0] total_od_i;
  logic [3:0] total_id_i;
  logic [7:0] weight_od1_o;
  logic [3:0] weight_id_o;
  logic       rd_req_o, pe_load_o, busy_o, done_o, err_o;
  logic [1:0] pair_mask_o;
`ifdef WEIGHT_SCHED_STALL_CNT_EN
  logic [15:0] stall_cnt_o;
`endif

  int passed = 0;
  int failed = 0;
  int total  = 0;
  int stall  = 0;

  weight_fetch_scheduler #(.TIMEOUT(64), .TO_W(7)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .abort_i(abort_i),
    .total_od_i(total_od_i), .total_id_i(total_id_i), .pe_ready_i(pe_ready_i),
    .mem_valid_i(mem_valid_i), .weight_od1_o(weight_od1_o), .weight_id_o(weight_id_o),
    .rd_req_o(rd_req_o), .pair_mask_o(pair_mask_o), .pe_load_o(pe_load_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
`ifdef WEIGHT_SCHED_STALL_CNT_EN
    , .stall_cnt_o(stall_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_od1"}, weight_od1_o, 0);
    chk({tag, "_id"}, weight_id_o, 0);
    chk({tag, "_mask"}, pair_mask_o, 0);
    chk({tag, "_rdreq"}, rd_req_o, 0);
    chk({tag, "_pload"}, pe_load_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_err"}, err_o, 0);
  endtask

  // act: 0 none, 1 reset at REQ of pair act_at, 2 abort in WAIT of pair act_at, 3 timeout at pair act_at
  task automatic run_layer(input int tod, input int tid, input bit rnd,
                           input int act, input int act_at, input int bp_at);
    int q_od[$];
    int q_id[$];
    logic [1:0] q_mk[$];
    bit done_seen;
    int lat;
    for (int i = 0; i < tid; i++)
      for (int o = 0; o < tod; o += 2) begin
        q_od.push_back(o);
        q_id.push_back(i);
        q_mk.push_back((o + 1 >= tod) ? 2'b01 : 2'b11);
      end
    stall      = 0;
    total_od_i = 8'(tod);
    total_id_i = 4'(tid);
    start_i    = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    chk("start_err_clr", err_o, 0);
    if (q_od.size() == 0) begin
      chk("zero_done", done_o, 1);
      chk("zero_busy", busy_o, 1);
      chk("zero_rdreq", rd_req_o, 0);
      @(negedge clk);
      chk("zero_done_end", done_o, 0);
      chk("zero_busy_end", busy_o, 0);
      chk("zero_rdreq_end", rd_req_o, 0);
      return;
    end
    for (int p = 0; p < q_od.size(); p++) begin
      int cyc = 0;
      while (rd_req_o !== 1'b1 && cyc < 200) begin
        if (p == bp_at && cyc < 10) begin
          pe_ready_i = 1'b0;
          chk("bp_hold_od1", weight_od1_o, q_od[p]);
        end else if (rnd) pe_ready_i = ($urandom_range(0, 3) != 0);
        else pe_ready_i = 1'b1;
        if (rnd) start_i = 1'($urandom_range(0, 1));
        if (!pe_ready_i) stall++;
        @(negedge clk);
        cyc++;
      end
      start_i = 1'b0;
      chk("req_seen", rd_req_o, 1);
      if (p == bp_at) chk("bp_latency", cyc, 11);
      else if (!rnd) chk("req_latency", cyc, 1);
      chk("req_od1", weight_od1_o, q_od[p]);
      chk("req_id", weight_id_o, q_id[p]);
      chk("req_mask", pair_mask_o, q_mk[p]);
      if (act == 1 && p == act_at) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_all_zero("mid_reset");
        return;
      end
      mem_valid_i = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      mem_valid_i = 1'b0;
      stall++;
      chk("req_pulse", rd_req_o, 0);
      chk("stray_load", pe_load_o, 0);
      if (act == 2 && p == act_at) begin
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        chk("abort_busy", busy_o, 0);
        chk("abort_done", done_o, 0);
        chk("abort_err", err_o, 0);
        mem_valid_i = 1'b1;
        @(negedge clk);
        mem_valid_i = 1'b0;
        chk("late_valid_load", pe_load_o, 0);
        chk("late_valid_busy", busy_o, 0);
        return;
      end
      if (act == 3 && p == act_at) begin
        done_seen = 1'b0;
        repeat (63) begin
          @(negedge clk);
          done_seen |= done_o;
        end
        chk("to_err_early", err_o, 0);
        chk("to_busy_early", busy_o, 1);
        @(negedge clk);
        done_seen |= done_o;
        chk("to_err", err_o, 1);
        chk("to_idle", busy_o, 0);
        chk("to_no_done", done_seen, 0);
        return;
      end
      lat = rnd ? int'($urandom_range(0, 3)) : 2;
      repeat (lat) begin
        if (rnd) start_i = 1'($urandom_range(0, 1));
        @(negedge clk);
        stall++;
      end
      start_i = 1'b0;
      chk("hold_od1", weight_od1_o, q_od[p]);
      chk("hold_mask", pair_mask_o, q_mk[p]);
      mem_valid_i = 1'b1;
      @(negedge clk);
      mem_valid_i = 1'b0;
      chk("pe_load", pe_load_o, 1);
      chk("done_on_last", done_o, (p == q_od.size() - 1));
    end
    @(negedge clk);
    chk("end_done", done_o, 0);
    chk("end_busy", busy_o, 0);
    chk("end_pload", pe_load_o, 0);
`ifdef WEIGHT_SCHED_STALL_CNT_EN
    chk("stall_cnt", stall_cnt_o, stall);
`endif
  endtask

  initial begin
    reset = 1'b1; start_i = 1'b0; abort_i = 1'b0; pe_ready_i = 1'b0; mem_valid_i = 1'b0;
    total_od_i = '0; total_id_i = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk_all_zero("reset");

    run_layer(4, 2, 1'b0, 0, -1, -1);   // even layer
    run_layer(5, 1, 1'b0, 0, -1, -1);   // odd tail
    run_layer(6, 2, 1'b0, 0, -1, 1);    // back-pressure on second pair
    run_layer(6, 0, 1'b0, 0, -1, -1);   // zero input depth
    run_layer(0, 3, 1'b0, 0, -1, -1);   // zero output depth
    run_layer(2, 1, 1'b0, 3, 0, -1);    // timeout
    run_layer(3, 2, 1'b0, 0, -1, -1);   // start clears err
    run_layer(8, 2, 1'b0, 2, 2, -1);    // abort in WAIT_DATA
    for (int n = 0; n < 8; n++)
      run_layer(int'($urandom_range(0, 12)), int'($urandom_range(0, 3)), 1'b1, 0, -1, -1);
    run_layer(8, 2, 1'b0, 1, 1, -1);    // reset during REQ
    run_layer(7, 2, 1'b1, 0, -1, -1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
